dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port (DMemory_IO) between the PMIPSL0 pipeline and a debug/loader master.
//  The CPU has fixed priority. The debug port is served when the CPU is idle.
//  A starvation counter forces a one-cycle debug slot and stalls the CPU pipeline for that cycle.
//  Sits between PMIPSL0 dmem* ports and DMemory_IO; debug side uses a 4-phase req/done handshake.
// PARAMETERS
//  STARVE_LIMIT  4   consecutive cycles of pending dbg_req denied before a debug slot is forced (1..255)
//  AW            16  address width
//  DW            16  data width
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high
//  cpu_addr    in   AW  CPU data address (dmemaddr)
//  cpu_wdata   in   DW  CPU write data
//  cpu_write   in   1   CPU write enable
//  cpu_read    in   1   CPU read enable
//  cpu_rdata   out  DW  read data to CPU (mem_rdata pass-through)
//  cpu_stall   out  1   freeze pipeline this cycle; CPU holds its request
//  dbg_req     in   1   debug request; held high until dbg_done seen
//  dbg_we      in   1   1=write, 0=read; stable while dbg_req=1
//  dbg_addr    in   AW  debug address
//  dbg_wdata   in   DW  debug write data
//  dbg_rdata   out  DW  registered debug read data
//  dbg_done    out  1   high from access completion until dbg_req falls
//  mem_addr    out  AW  to DMemory_IO
//  mem_wdata   out  DW  to DMemory_IO
//  mem_write   out  1   to DMemory_IO; memory writes on rising clock
//  mem_read    out  1   to DMemory_IO; read data combinational
//  mem_rdata   in   DW  from DMemory_IO
// BEHAVIOUR
//  - States: ARB (arbitrate), DONE (debug access finished, waiting for dbg_req=0).
//  - cpu_act = cpu_read|cpu_write; dbg_pend = dbg_req & (state==ARB).
//  - force = dbg_pend & (starve_cnt==STARVE_LIMIT).
//  - Grant each cycle (combinational):
//    - force -> debug owns port; cpu_stall=cpu_act.
//    - else cpu_act -> CPU owns port; cpu_stall=0.
//    - else dbg_pend -> debug owns port.
//    - else idle: mem_read=mem_write=0; mem_addr/mem_wdata=CPU values.
//  - Debug grant: mem_addr=dbg_addr, mem_wdata=dbg_wdata, mem_write=dbg_we, mem_read=~dbg_we.
//    - At the clock edge: dbg_rdata<=mem_rdata on a read (unchanged on a write), state->DONE, dbg_done<=1, starve_cnt<=0.
//    - Latency: req seen with CPU idle -> dbg_done high 1 clock later.
//  - starve_cnt: +1 each cycle dbg_pend is denied. Cleared on debug grant and whenever dbg_pend=0. Never exceeds STARVE_LIMIT.
//  - DONE: debug is never granted. dbg_req=0 -> dbg_done<=0, state->ARB. A new request needs dbg_req to fall then rise again.
//  - A CPU access in DONE proceeds unstalled.
//  - Stalled CPU request is served the next cycle; at most 1 stall cycle per debug access.
//  - dbg_req dropped in ARB before grant: request abandoned, no access, starve_cnt cleared.
//  - Reset (async, any state, including mid-forced-slot):
//    - state=ARB, starve_cnt=0, dbg_done=0, dbg_rdata=0.
//    - While reset=1: mem_write=0, mem_read=0, cpu_stall=0.
//  - cpu_rdata = mem_rdata always. CPU sees valid data only in cycles it owns the port.
// CONFIGURATION
//  - DMEM_ARB_STATS_EN defined: adds outputs stall_cnt[15:0] and dbg_cnt[15:0].
//    - stall_cnt: cycles with cpu_stall=1.
//    - dbg_cnt: completed debug accesses.
//    - Both saturate at 16'hFFFF and reset to 0.
//  - DMEM_ARB_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - CPU idle; debug write addr 16'h0010 data 16'h1234, then debug read 16'h0010
//    -> mem_write pulse 1 cycle; dbg_done 1 clock after each req; dbg_rdata=16'h1234.
//  - CPU reads every cycle, dbg_req held from t0, STARVE_LIMIT=4
//    -> debug granted cycle 5; cpu_stall=1 that cycle only; CPU address re-presented and served cycle 6.
//  - CPU writes 16'h00AA to 16'h0020 in same cycle debug requests (starve_cnt=0)
//    -> CPU wins; mem_addr=16'h0020; dbg_done stays 0; starve_cnt=1.
//  - dbg_req held high after dbg_done
//    -> no second access; dbg_req low 1 cycle then high -> new access.
//  - reset asserted during forced slot -> mem_write=0 immediately, dbg_done=0, cpu_stall=0; after release CPU served first.
//  - STATS_EN: 3 forced slots -> stall_cnt=3; 5 debug accesses -> dbg_cnt=5.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and data-memory signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // CPU pipeline side
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_write;
  logic          cpu_read;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  // Debug/loader side (4-phase req/done)
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;
  // Data memory side
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write, cpu_read,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  // Environment view (CPU, debug master and memory together)
  modport master (
    output cpu_addr, cpu_wdata, cpu_write, cpu_read,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done,
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data-memory arbiter with starvation-forced debug slot; DMEM_ARB_STATS_EN adds stall_cnt/dbg_cnt
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic clock,
  input  logic reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] dbg_cnt
`endif
);

  typedef enum logic {
    ARB  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    starve_cnt;

  logic          cpu_act;
  logic          dbg_pend;
  logic          force_dbg;
  logic          dbg_grant;
  logic          stall;
  logic          wr;
  logic          rd;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Grant decision, port mux and next state
  always_comb begin
    state_nxt = state;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    wr        = 1'b0;
    rd        = 1'b0;
    stall     = 1'b0;

    cpu_act   = bus.cpu_read | bus.cpu_write;
    dbg_pend  = bus.dbg_req & (state == ARB);
    force_dbg = dbg_pend & (starve_cnt == 8'(STARVE_LIMIT));
    dbg_grant = force_dbg | (dbg_pend & ~cpu_act);

    if (dbg_grant) begin
      sel_addr  = bus.dbg_addr;
      sel_wdata = bus.dbg_wdata;
      wr        = bus.dbg_we;
      rd        = ~bus.dbg_we;
      stall     = force_dbg & cpu_act;
    end else if (cpu_act) begin
      wr = bus.cpu_write;
      rd = bus.cpu_read;
    end

    case (state)
      ARB:  if (dbg_grant) state_nxt = DONE;
      DONE: if (!bus.dbg_req) state_nxt = ARB;
    endcase
  end

  // Strobes are held off for as long as reset is asserted
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;
  assign bus.mem_write = wr & ~reset;
  assign bus.mem_read  = rd & ~reset;
  assign bus.cpu_stall = stall & ~reset;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dbg_done  = (state == DONE);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ARB;
    else       state <= state_nxt;
  end

  // Starvation counter: counts denied cycles of a live debug request
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      starve_cnt <= 8'd0;
    else if (dbg_grant || !dbg_pend) starve_cnt <= 8'd0;
    else                            starve_cnt <= starve_cnt + 8'd1;
  end

  // Capture debug read data on the granted read cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         bus.dbg_rdata <= '0;
    else if (dbg_grant && !bus.dbg_we) bus.dbg_rdata <= bus.mem_rdata;
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating stall-cycle and debug-access counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      dbg_cnt   <= 16'd0;
    end else begin
      if (stall && stall_cnt != 16'hFFFF)   stall_cnt <= stall_cnt + 16'd1;
      if (dbg_grant && dbg_cnt != 16'hFFFF) dbg_cnt   <= dbg_cnt + 16'd1;
    end
  end
`endif

endmodule
